// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller: register offsets, UCON bit
// positions, TX FSM encoding and the UCON read-value packer.
package uart_pkg;

    localparam logic [31:0] OFF_TXD  = 32'd0;
    localparam logic [31:0] OFF_RXD  = 32'd4;
    localparam logic [31:0] OFF_UCON = 32'd8;

    localparam int UCON_TX_IRQ_EN = 0;
    localparam int UCON_RX_IRQ_EN = 1;
    localparam int UCON_RX_VALID  = 2;
    localparam int UCON_FULL      = 3;
    localparam int UCON_EMPTY     = 4;
    localparam int UCON_TX_BUSY   = 5;
    localparam int UCON_OVERRUN   = 6;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_e;

    // Bits not listed here always read as zero.
    function automatic logic [31:0] ucon_pack(
        input logic [1:0] irq_en,
        input logic       rx_valid,
        input logic       fifo_full,
        input logic       fifo_empty,
        input logic       tx_busy,
        input logic       rx_overrun
    );
        logic [31:0] v;
        v                 = 32'd0;
        v[UCON_TX_IRQ_EN] = irq_en[0];
        v[UCON_RX_IRQ_EN] = irq_en[1];
        v[UCON_RX_VALID]  = rx_valid;
        v[UCON_FULL]      = fifo_full;
        v[UCON_EMPTY]     = fifo_empty;
        v[UCON_TX_BUSY]   = tx_busy;
        v[UCON_OVERRUN]   = rx_overrun;
        return v;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular TX byte FIFO; pointers carry one extra wrap bit so full and empty
// are told apart without a separate counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int WIDTH    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int IDX_W = $clog2(TX_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [TX_DEPTH];
    logic [WIDTH-1:0] mem_d [TX_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]) &&
                   (wptr_q[IDX_W] != rptr_q[IDX_W]);
    assign dout  = mem_q[rptr_q[IDX_W-1:0]];

    // Next-state: a pop frees the head slot, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    always_comb begin
        mem_d     = mem_q;
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
        if (do_push_s) begin
            mem_d[wptr_q[IDX_W-1:0]] = din;
            wptr_d = wptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (do_pop_s) begin
            rptr_d = rptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wptr_q <= {PTR_W{1'b0}};
            rptr_q <= {PTR_W{1'b0}};
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller (TXD / RXD / UCON) with TX FIFO and RX holding
// register. Define UART_IRQ_EN to enable the interrupt output and UCON enables.
module uart_bus_ctrl
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0018,
    parameter int          TX_DEPTH    = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_status,
    input  logic        uart_tx_status,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_en,
    output logic        irq
);

    logic [SYNC_STAGES-1:0] tx_sync_q, tx_sync_d;
    logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
    logic                   rx_prev_q, rx_prev_d;
    tx_state_e              state_q, state_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_en_q, tx_en_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_overrun_q, rx_overrun_d;

    logic       ts_s, rx_rise_s;
    logic       sel_txd_s, sel_rxd_s, sel_ucon_s;
    logic       wr_txd_s, rd_rxd_s, wr_ucon_s;
    logic       fifo_pop_s, fifo_full_s, fifo_empty_s;
    logic [7:0] fifo_dout_s;
    logic       tx_busy_s;
    logic [1:0] irq_en_s;
    logic       unused_ok_s;

    assign unused_ok_s = ^wdata[31:8];

    assign sel_txd_s  = (addr == BASE_ADDR + OFF_TXD);
    assign sel_rxd_s  = (addr == BASE_ADDR + OFF_RXD);
    assign sel_ucon_s = (addr == BASE_ADDR + OFF_UCON);
    assign wr_txd_s   = mem_write & sel_txd_s;
    assign rd_rxd_s   = mem_read & sel_rxd_s;
    assign wr_ucon_s  = mem_write & sel_ucon_s;

    assign ts_s      = tx_sync_q[SYNC_STAGES-1];
    assign tx_busy_s = (state_q != TX_IDLE);

    assign uart_tx_data = tx_data_q;
    assign uart_tx_en   = tx_en_q;

    uart_tx_fifo #(
        .TX_DEPTH (TX_DEPTH),
        .WIDTH    (8)
    ) u_fifo (
        .clk   (sysclk),
        .reset (reset),
        .push  (wr_txd_s),
        .pop   (fifo_pop_s),
        .din   (wdata[7:0]),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Bus read mux.
    always_comb begin
        rdata = 32'd0;
        if (mem_read && sel_txd_s) begin
            rdata = {31'd0, fifo_full_s};
        end else if (mem_read && sel_rxd_s) begin
            rdata = {24'd0, rx_data_q};
        end else if (mem_read && sel_ucon_s) begin
            rdata = ucon_pack(irq_en_s, rx_valid_q, fifo_full_s, fifo_empty_s,
                              tx_busy_s, rx_overrun_q);
        end else begin
            rdata = 32'd0;
        end
    end

    // Status synchronisers and the RX rising-edge detector.
    always_comb begin
        tx_sync_d = {tx_sync_q[SYNC_STAGES-2:0], uart_tx_status};
        rx_sync_d = {rx_sync_q[SYNC_STAGES-2:0], uart_rx_status};
        rx_prev_d = rx_sync_q[SYNC_STAGES-1];
        rx_rise_s = rx_sync_q[SYNC_STAGES-1] & ~rx_prev_q;
    end

    // RX holding register; uart_rx_data is stable by the time the completion
    // level has crossed the synchroniser, so it is captured directly.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        if (rx_rise_s) begin
            rx_data_d  = uart_rx_data;
            rx_valid_d = 1'b1;
            if (rd_rxd_s) begin
                rx_overrun_d = rx_overrun_q;
            end else begin
                rx_overrun_d = rx_overrun_q | rx_valid_q;
            end
        end else if (rd_rxd_s) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
        end else if (wr_ucon_s && wdata[UCON_OVERRUN]) begin
            rx_overrun_d = 1'b0;
        end else begin
            rx_overrun_d = rx_overrun_q;
        end
    end

    // TX FSM: the byte is latched at IDLE exit and held until the sender is
    // seen idle again, since it samples uart_tx_data through the frame.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_en_d    = tx_en_q;
        fifo_pop_s = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (!fifo_empty_s && ts_s) begin
                    tx_data_d  = fifo_dout_s;
                    fifo_pop_s = 1'b1;
                    tx_en_d    = 1'b1;
                    state_d    = TX_LOAD;
                end else begin
                    tx_en_d = 1'b0;
                end
            end
            TX_LOAD: begin
                if (!ts_s) begin
                    tx_en_d = 1'b0;
                    state_d = TX_BUSY;
                end else begin
                    tx_en_d = 1'b1;
                end
            end
            TX_BUSY: begin
                if (ts_s) begin
                    state_d = TX_IDLE;
                end else begin
                    state_d = TX_BUSY;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_en_d = 1'b0;
            end
        endcase
    end

    // Core register bank.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_sync_q    <= {SYNC_STAGES{1'b1}};
            rx_sync_q    <= {SYNC_STAGES{1'b0}};
            rx_prev_q    <= 1'b0;
            state_q      <= TX_IDLE;
            tx_data_q    <= 8'd0;
            tx_en_q      <= 1'b0;
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            tx_sync_q    <= tx_sync_d;
            rx_sync_q    <= rx_sync_d;
            rx_prev_q    <= rx_prev_d;
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_en_q      <= tx_en_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            rx_overrun_q <= rx_overrun_d;
        end
    end

`ifdef UART_IRQ_EN
    logic [1:0] irq_en_q, irq_en_d;
    logic       irq_q, irq_d;

    // Interrupt enables and registered interrupt request.
    always_comb begin
        if (wr_ucon_s) begin
            irq_en_d = wdata[UCON_RX_IRQ_EN:UCON_TX_IRQ_EN];
        end else begin
            irq_en_d = irq_en_q;
        end
        irq_d = (irq_en_q[0] & fifo_empty_s & ~tx_busy_s) |
                (irq_en_q[1] & rx_valid_q);
    end

    // Interrupt register bank.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            irq_en_q <= 2'b00;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign irq_en_s = irq_en_q;
    assign irq      = irq_q;
`else
    assign irq_en_s = 2'b00;
    assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Scoreboard bench for uart_bus_ctrl: a behavioural sender consumes frames and
// checks them against queued expectations; a read monitor checks bus reads.
module tb_uart_bus_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] A_TXD  = BASE;
    localparam logic [31:0] A_RXD  = BASE + 32'd4;
    localparam logic [31:0] A_UCON = BASE + 32'd8;
    localparam int DEPTH = 4;

    logic        sysclk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [7:0]  uart_rx_data = 8'd0;
    logic        uart_rx_status = 1'b0;
    logic        uart_tx_status = 1'b1;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_en;
    logic        irq;

    uart_bus_ctrl #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .addr           (addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .uart_rx_data   (uart_rx_data),
        .uart_rx_status (uart_rx_status),
        .uart_tx_status (uart_tx_status),
        .uart_tx_data   (uart_tx_data),
        .uart_tx_en     (uart_tx_en),
        .irq            (irq)
    );

    always #5 sysclk = ~sysclk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  tx_sb_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];

    // Reference model state.
    logic [7:0] m_rx_data = 8'd0;
    logic       m_rx_valid = 1'b0;
    logic       m_rx_ovr = 1'b0;
    logic [1:0] m_irq_en = 2'b00;

    // Sender model controls.
    bit manual = 1'b0;
    bit stall = 1'b0;
    bit sender_busy = 1'b0;
    int frame_len = 4;
    int sent_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_ucon(input logic full, input logic empty, input logic busy);
        return {25'd0, m_rx_ovr, busy, empty, full, m_rx_valid, m_irq_en};
    endfunction

    // Read monitor: compare rdata whenever the bus read strobe is presented.
    always @(negedge sysclk) begin
        if (mem_read) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_unexpected", rdata, 32'hDEAD_BEEF);
            end else begin
                check(rd_name_q.pop_front(), rdata, rd_exp_q.pop_front());
            end
        end
    end

    // Sender model: accepts a request while idle, runs a frame, then returns idle.
    initial begin : sender
        logic [7:0] b;
        forever begin
            @(negedge sysclk);
            if (manual) continue;
            if (stall) begin
                uart_tx_status = 1'b0;
                continue;
            end
            uart_tx_status = 1'b1;
            if (uart_tx_en) begin
                sender_busy = 1'b1;
                b = uart_tx_data;
                if (tx_sb_q.size() == 0) check("tx_unexpected", {24'd0, b}, 32'hFFFF_FFFF);
                else check("tx_byte", {24'd0, b}, {24'd0, tx_sb_q.pop_front()});
                repeat ($urandom_range(0, 2)) @(negedge sysclk);
                uart_tx_status = 1'b0;
                repeat (frame_len + $urandom_range(0, 3)) @(negedge sysclk);
                check("tx_en_released", {31'd0, uart_tx_en}, 32'd0);
                check("tx_data_held", {24'd0, uart_tx_data}, {24'd0, b});
                uart_tx_status = 1'b1;
                sent_cnt++;
                sender_busy = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge sysclk); #1;
        addr = a; wdata = d; mem_write = 1'b1;
        @(posedge sysclk); #1;
        mem_write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        @(posedge sysclk); #1;
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        addr = a; mem_read = 1'b1;
        @(posedge sysclk); #1;
        mem_read = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b);
        @(posedge sysclk); #1;
        uart_rx_data = b; uart_rx_status = 1'b1;
        repeat (3) @(posedge sysclk);
        #1 uart_rx_status = 1'b0;
        repeat (6) @(posedge sysclk);
        if (m_rx_valid) m_rx_ovr = 1'b1;
        m_rx_data = b;
        m_rx_valid = 1'b1;
    endtask

    task automatic read_rxd(input string name);
        bus_read(A_RXD, {24'd0, m_rx_data}, name);
        m_rx_valid = 1'b0;
        m_rx_ovr = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && (tx_sb_q.size() != 0 || sender_busy); i++) @(posedge sysclk);
        if (i >= 3000) check("drain_timeout", tx_sb_q.size(), 32'd0);
        repeat (6) @(posedge sysclk);
    endtask

    initial begin : stim
        int base_cnt;
        int n;
        logic [7:0] b;
        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        @(negedge sysclk);
        check("reset_tx_en", {31'd0, uart_tx_en}, 32'd0);
        check("reset_tx_data", {24'd0, uart_tx_data}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        bus_read(A_UCON, exp_ucon(1'b0, 1'b1, 1'b0), "reset_ucon");
        bus_read(A_TXD, 32'd0, "reset_txd");
        bus_read(A_RXD, 32'd0, "reset_rxd");

        // Two bytes, long frames: busy visible, order preserved.
        frame_len = 20;
        base_cnt = sent_cnt;
        tx_sb_q.push_back(8'h55); bus_write(A_TXD, 32'h55);
        tx_sb_q.push_back(8'hA3); bus_write(A_TXD, 32'hA3);
        repeat (6) @(posedge sysclk);
        bus_read(A_UCON, exp_ucon(1'b0, 1'b0, 1'b1), "ucon_busy");
        bus_read(A_TXD, 32'd0, "txd_not_full");
        drain();
        check("two_sent", sent_cnt - base_cnt, 32'd2);
        frame_len = 4;

        // Sender stalled: fifth write is dropped.
        stall = 1'b1;
        repeat (4) @(posedge sysclk);
        base_cnt = sent_cnt;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) tx_sb_q.push_back(b);
            bus_write(A_TXD, {24'd0, b});
        end
        bus_read(A_UCON, exp_ucon(1'b1, 1'b0, 1'b0), "ucon_full");
        bus_read(A_TXD, 32'd1, "txd_full");
        stall = 1'b0;
        drain();
        check("four_sent", sent_cnt - base_cnt, DEPTH);

        // Single RX frame.
        rx_frame(8'h3C);
        bus_read(A_UCON, exp_ucon(1'b0, 1'b1, 1'b0), "ucon_rx_valid");
        read_rxd("rxd_3c");
        bus_read(A_UCON, exp_ucon(1'b0, 1'b1, 1'b0), "ucon_rx_cleared");

        // Overrun, then write-1-clear.
        rx_frame(8'h11);
        rx_frame(8'h22);
        bus_read(A_UCON, exp_ucon(1'b0, 1'b1, 1'b0), "ucon_overrun");
        bus_write(A_UCON, 32'h40);
        m_rx_ovr = 1'b0;
        bus_read(A_UCON, exp_ucon(1'b0, 1'b1, 1'b0), "ucon_ovr_w1c");
        read_rxd("rxd_22");

        // Reset while holding a request in LOAD with three bytes queued.
        manual = 1'b1;
        uart_tx_status = 1'b1;
        for (int i = 1; i <= 4; i++) bus_write(A_TXD, i);
        repeat (4) @(posedge sysclk);
        @(negedge sysclk);
        check("load_tx_en", {31'd0, uart_tx_en}, 32'd1);
        check("load_tx_data", {24'd0, uart_tx_data}, 32'h01);
        bus_read(A_UCON, exp_ucon(1'b0, 1'b0, 1'b1), "ucon_load");
        @(posedge sysclk); #1;
        uart_tx_status = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge sysclk);
        #1 reset = 1'b0;
        m_irq_en = 2'b00;
        @(negedge sysclk);
        check("rst_tx_en", {31'd0, uart_tx_en}, 32'd0);
        check("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
        bus_read(A_UCON, exp_ucon(1'b0, 1'b1, 1'b0), "ucon_after_rst");
        repeat (4) @(posedge sysclk);
        base_cnt = sent_cnt;
        bus_write(A_TXD, 32'h7E);
        repeat (8) @(posedge sysclk);
        @(negedge sysclk);
        check("no_issue_while_busy", {31'd0, uart_tx_en}, 32'd0);
        bus_read(A_UCON, exp_ucon(1'b0, 1'b0, 1'b0), "ucon_queued");
        tx_sb_q.push_back(8'h7E);
        manual = 1'b0;
        drain();
        check("7e_sent", sent_cnt - base_cnt, 32'd1);

        // Randomised TX batches.
        for (int k = 0; k < 6; k++) begin
            frame_len = $urandom_range(4, 8);
            n = $urandom_range(1, DEPTH);
            base_cnt = sent_cnt;
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                tx_sb_q.push_back(b);
                bus_write(A_TXD, {24'd0, b});
            end
            drain();
            check("batch_count", sent_cnt - base_cnt, n);
        end

        // Randomised RX bursts.
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(1, 2);
            for (int i = 0; i < n; i++) rx_frame(8'($urandom));
            bus_read(A_UCON, exp_ucon(1'b0, 1'b1, 1'b0), "ucon_rand_rx");
            read_rxd("rxd_rand");
        end

`ifdef UART_IRQ_EN
        bus_write(A_UCON, 32'h2);
        m_irq_en = 2'b10;
        bus_read(A_UCON, exp_ucon(1'b0, 1'b1, 1'b0), "ucon_irq_en");
        check("irq_idle", {31'd0, irq}, 32'd0);
        rx_frame(8'h5A);
        check("irq_rx", {31'd0, irq}, 32'd1);
        read_rxd("rxd_irq");
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        bus_write(A_UCON, 32'h1);
        m_irq_en = 2'b01;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        check("irq_tx_empty", {31'd0, irq}, 32'd1);
        bus_write(A_UCON, 32'h0);
        m_irq_en = 2'b00;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        check("irq_off", {31'd0, irq}, 32'd0);
`else
        bus_write(A_UCON, 32'h3);
        bus_read(A_UCON, exp_ucon(1'b0, 1'b1, 1'b0), "ucon_en_ignored");
        rx_frame(8'h5A);
        check("irq_tied_low", {31'd0, irq}, 32'd0);
        read_rxd("rxd_5a");
`endif

        repeat (4) @(posedge sysclk);
        check("rd_queue_empty", rd_exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
